data_merger: RTL and testbench

DATA_MERGER -- requirements
Module: data_merger

---
 rtl/data_merger_pkg.sv | 17 +
 rtl/data_merger.sv | 105 ++++++++++
 tb/tb_data_merger.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_merger_pkg.sv
// -----------------------------------------------------------------------------
// data_merger_pkg
// Shared project constants for the byte-stream datapath: the splitter, the
// merger and the cache datapath all agree on byte width and default word size.
// -----------------------------------------------------------------------------
package data_merger_pkg;

    localparam int BYTE_WIDTH         = 8;
    localparam int WORD_BYTES_DEFAULT = 4;

    // Width of a byte-index counter for a word of word_bytes bytes.
    // A one-byte word still needs a 1-bit counter port.
    function automatic int cnt_width(input int word_bytes);
        return (word_bytes > 1) ? $clog2(word_bytes) : 1;
    endfunction

endpackage

// File: rtl/data_merger.sv
// -----------------------------------------------------------------------------
// data_merger
// Packs a stream of bytes into WORD_BYTES-byte words, big-endian bit numbering:
// the first byte of a word lands in d_out[0:7]. Inverse of the word-to-byte
// splitter.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   d_in         byte from upstream            (valid/ready handshake)
//   d_in_valid   upstream byte present
//   d_in_ready   byte is accepted this cycle when d_in_valid is also high
//   clear        synchronous discard of the partially assembled word
//   d_out        assembled word, held stable until consumed
//   d_out_valid  d_out holds a complete word
//   d_out_ready  downstream consumes d_out this cycle
//   fill_count   number of bytes held in the partial word
// -----------------------------------------------------------------------------
module data_merger
    import data_merger_pkg::*;
#(
    parameter int  WORD_BYTES = WORD_BYTES_DEFAULT,
    localparam int WORD_W     = BYTE_WIDTH * WORD_BYTES,
    localparam int CNT_W      = cnt_width(WORD_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:BYTE_WIDTH-1] d_in,
    input  logic              d_in_valid,
    output logic              d_in_ready,
    input  logic              clear,
    output logic [0:WORD_W-1] d_out,
    output logic              d_out_valid,
    input  logic              d_out_ready,
    output logic [0:CNT_W-1]  fill_count
);

    localparam logic [0:CNT_W-1] LAST_IDX = CNT_W'(WORD_BYTES - 1);

    logic [0:WORD_W-1] partial_p0;
    logic [0:WORD_W-1] partial_next;
    logic [0:CNT_W-1]  fill_p0;
    logic [0:WORD_W-1] word_p1;
    logic              vld_p1;

    logic at_last;
    logic accept;
    logic consume;

    assign at_last = (fill_p0 == LAST_IDX);
    assign consume = vld_p1 && d_out_ready;

    // The final byte may only enter when the output register is free or is
    // being emptied this very cycle; earlier bytes never wait on downstream.
    assign d_in_ready = !clear && !(at_last && vld_p1 && !d_out_ready);
    assign accept     = d_in_valid && d_in_ready;

    // Drop the incoming byte into its slot; on the last byte this is the
    // complete word.
    always_comb begin
        partial_next = partial_p0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (fill_p0 == CNT_W'(k)) begin
                partial_next[BYTE_WIDTH*k +: BYTE_WIDTH] = d_in;
            end
        end
    end

    // ---- stage p0: byte collection / stage p1: completed word ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_p0    <= '0;
            partial_p0 <= '0;
            word_p1    <= '0;
            vld_p1     <= 1'b0;
        end else begin
            if (clear) begin
                fill_p0    <= '0;
                partial_p0 <= '0;
            end else if (accept) begin
                if (at_last) begin
                    fill_p0    <= '0;
                    partial_p0 <= '0;
                end else begin
                    fill_p0    <= fill_p0 + CNT_W'(1);
                    partial_p0 <= partial_next;
                end
            end

            // A completing word wins over consumption so back-to-back words
            // keep valid high without a bubble.
            if (accept && at_last) begin
                word_p1 <= partial_next;
                vld_p1  <= 1'b1;
            end else if (consume) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign d_out       = word_p1;
    assign d_out_valid = vld_p1;
    assign fill_count  = fill_p0;

endmodule

// File: tb/tb_data_merger.sv
module tb_data_merger;

    localparam int WB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:7]  d_in = '0;
    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic        clear = 1'b0;
    logic [0:31] d_out;
    logic        d_out_valid;
    logic        d_out_ready = 1'b0;
    logic [0:1]  fill_count;

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard state
    logic [31:0] exp_q[$];
    logic [31:0] m_asm;
    int          m_cnt = 0;
    int          n_words_out = 0;
    bit          mon_en = 0;

    data_merger #(.WORD_BYTES(WB)) dut (
        .clk(clk), .rst(rst),
        .d_in(d_in), .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
        .clear(clear),
        .d_out(d_out), .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
        .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog timeout: run did not complete");
        $fatal(1, "watchdog");
    end

    // Reference model: tracks accepted bytes from the bench's own view of the
    // handshake rules, pushes each completed word, pops on consumption.
    always @(negedge clk) begin
        logic        exp_vld;
        logic        exp_rdy;
        logic [31:0] exp_w;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_asm = '0;
        end else if (mon_en) begin
            exp_vld = (exp_q.size() != 0);
            exp_rdy = !clear && !(m_cnt == WB - 1 && exp_vld && !d_out_ready);
            n_cmp++;
            if (d_out_valid !== exp_vld) begin
                n_bad++;
                $display("FAIL mon_out_valid got=%b exp=%b t=%0t", d_out_valid, exp_vld, $time);
            end
            n_cmp++;
            if (d_in_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL mon_in_ready got=%b exp=%b t=%0t", d_in_ready, exp_rdy, $time);
            end
            n_cmp++;
            if (fill_count !== 2'(m_cnt)) begin
                n_bad++;
                $display("FAIL mon_fill_count got=%0d exp=%0d t=%0t", fill_count, m_cnt, $time);
            end
            if (exp_vld && d_out_ready) begin
                exp_w = exp_q.pop_front();
                n_words_out++;
                n_cmp++;
                if (d_out !== exp_w) begin
                    n_bad++;
                    $display("FAIL mon_word got=%h exp=%h t=%0t", d_out, exp_w, $time);
                end
            end
            if (clear) begin
                m_cnt = 0;
            end else if (d_in_valid && exp_rdy) begin
                m_asm[31 - 8*m_cnt -: 8] = d_in;
                m_cnt++;
                if (m_cnt == WB) begin
                    exp_q.push_back(m_asm);
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        d_in = b;
        d_in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = d_in_ready;
            tick();
        end
        d_in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte_timeout byte=%h not accepted within 50 cycles", b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b0 || d_out !== 32'h0 || fill_count !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state got vld=%b out=%h fill=%0d exp 0/0/0", d_out_valid, d_out, fill_count);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got=%b exp=1", d_in_ready);
        end
        tick();
        mon_en = 1;
    endtask

    task automatic test_deadbeef();
        logic [7:0] bytes [4];
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        d_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in = bytes[i];
            d_in_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (d_in_ready !== 1'b1 || fill_count !== 2'(i)) begin
                n_bad++;
                $display("FAIL deadbeef_accept i=%0d got rdy=%b fill=%0d exp 1/%0d", i, d_in_ready, fill_count, i);
            end
            tick();
        end
        d_in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b1 || d_out !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL deadbeef_word got vld=%b out=%h exp 1/deadbeef", d_out_valid, d_out);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL deadbeef_one_cycle got vld=%b exp 0", d_out_valid);
        end
        tick();
    endtask

    task automatic test_held_word();
        d_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        d_in = 8'h44;
        d_in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (d_in_ready !== 1'b0 || d_out !== 32'hA0A1A2A3 || d_out_valid !== 1'b1 || fill_count !== 2'd3) begin
                n_bad++;
                $display("FAIL held_stall c=%0d got rdy=%b out=%h vld=%b fill=%0d exp 0/a0a1a2a3/1/3",
                         c, d_in_ready, d_out, d_out_valid, fill_count);
            end
            tick();
        end
        d_out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL held_release_ready got=%b exp=1", d_in_ready);
        end
        tick();
        d_in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b1 || d_out !== 32'h11223344) begin
            n_bad++;
            $display("FAIL held_next_word got vld=%b out=%h exp 1/11223344", d_out_valid, d_out);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL held_drained got vld=%b exp 0", d_out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        d_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_in = 8'(i + 1);
            d_in_valid = (i < 8);
            @(negedge clk);
            if (i < 8) begin
                n_cmp++;
                if (d_in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_stall i=%0d got rdy=%b exp 1", i, d_in_ready);
                end
            end
            if (i == 4 || i == 8) begin
                n_cmp++;
                if (d_out_valid !== 1'b1 || d_out !== ((i == 4) ? 32'h01020304 : 32'h05060708)) begin
                    n_bad++;
                    $display("FAIL b2b_word i=%0d got vld=%b out=%h", i, d_out_valid, d_out);
                end
            end else begin
                n_cmp++;
                if (d_out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_gap i=%0d got vld=%b exp 0", i, d_out_valid);
                end
            end
            tick();
        end
        d_in_valid = 1'b0;
    endtask

    task automatic test_clear();
        d_out_ready = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        d_in = 8'hCC;
        d_in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_ready got=%b exp 0", d_in_ready);
        end
        tick();
        clear = 1'b0;
        d_in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fill_count !== 2'd0 || d_out !== 32'h05060708 || d_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_state got fill=%0d out=%h vld=%b exp 0/05060708/0", fill_count, d_out, d_out_valid);
        end
        tick();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b1 || d_out !== 32'h01020304) begin
            n_bad++;
            $display("FAIL clear_word got vld=%b out=%h exp 1/01020304", d_out_valid, d_out);
        end
        tick();
        // clear with a held word: output untouched
        d_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b1 || d_out !== 32'h50515253 || fill_count !== 2'd0) begin
            n_bad++;
            $display("FAIL clear_held got vld=%b out=%h fill=%0d exp 1/50515253/0", d_out_valid, d_out, fill_count);
        end
        tick();
        d_out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        d_out_ready = 1'b1;
        send_byte(8'h10);
        send_byte(8'h20);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (fill_count !== 2'd0 || d_out_valid !== 1'b0 || d_out !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid_word got fill=%0d vld=%b out=%h exp 0/0/0", fill_count, d_out_valid, d_out);
        end
        tick();
        rst = 1'b0;
        d_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
        rst = 1'b1;
        #1;
        n_cmp++;
        if (fill_count !== 2'd0 || d_out_valid !== 1'b0 || d_out !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_held got fill=%0d vld=%b out=%h exp 0/0/0", fill_count, d_out_valid, d_out);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ready got=%b exp 1", d_in_ready);
        end
        tick();
        d_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
        @(negedge clk);
        n_cmp++;
        if (d_out_valid !== 1'b1 || d_out !== 32'hC0C1C2C3) begin
            n_bad++;
            $display("FAIL rst_after_word got vld=%b out=%h exp 1/c0c1c2c3", d_out_valid, d_out);
        end
        tick();
        tick();
    endtask

    task automatic test_random();
        int         sent = 0;
        int         cycles = 0;
        int         start_words;
        bit         have = 0;
        logic [7:0] cur = '0;
        start_words = n_words_out;
        while (sent < 4 * 1000 && cycles < 40000) begin
            if (!have) begin
                cur = 8'($urandom);
                have = 1;
            end
            d_in = cur;
            d_in_valid = ($urandom_range(0, 3) != 0);
            d_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (d_in_valid && d_in_ready) begin
                have = 0;
                sent++;
            end
            tick();
            cycles++;
        end
        d_in_valid = 1'b0;
        d_out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        n_cmp++;
        if (n_words_out - start_words !== 1000 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL random_words got=%0d left=%0d exp 1000/0 (bytes sent %0d)",
                     n_words_out - start_words, exp_q.size(), sent);
        end
    endtask

    initial begin
        test_reset();
        test_deadbeef();
        test_held_word();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
